grayscale_sidebuf: RTL and testbench

Side buffer between the `grayscale` pipeline output and the write-request path of `grayscale_requestor`. `grayscale` has no backpressure: every `valid_out` beat must be captured. This block therefore stores result lines in a FIFO, drains them to the requestor under a valid/ready handshake (ready = write channel not almost-full), and runs a reservation counter. That counter stops the requestor from issuing reads whose results could overflow the buffer. Overflow and credit violations are latched as sticky error flags for the CSR block.

---
 rtl/grayscale_sidebuf_pkg.sv | 11 +
 rtl/grayscale_sidebuf_if.sv | 23 ++
 rtl/grayscale_sidebuf_credit.sv | 55 +++++
 rtl/grayscale_sidebuf.sv | 91 +++++++++
 tb/tb_grayscale_sidebuf.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grayscale_sidebuf_pkg.sv
// Shared definitions for the grayscale side buffer: default depth and
// the line/occupancy types used between the pipeline and the requestor.
package grayscale_pkg;

   localparam int SIDEBUF_DEPTH = 64;
   localparam int SIDEBUF_CNT_W = $clog2(SIDEBUF_DEPTH) + 1;

   typedef logic [$clog2(SIDEBUF_DEPTH):0] t_sidebuf_count;
   typedef logic [511:0]                   t_sidebuf_line;

endpackage

// File: rtl/grayscale_sidebuf_if.sv
// Stream and credit signals between grayscale, the side buffer and the
// write-request path; the buffer sits on the slave side.
interface grayscale_sidebuf_if #(
   parameter int DATA_WIDTH = 512
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  valid_in;
   logic                  rd_issue;
   logic                  credit_ok;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  ready_in;

   modport master (
      output data_in, valid_in, rd_issue, ready_in,
      input  credit_ok, data_out, valid_out
   );

   modport slave (
      input  data_in, valid_in, rd_issue, ready_in,
      output credit_ok, data_out, valid_out
   );
endinterface

// File: rtl/grayscale_sidebuf_credit.sv
// Saturating reservation counter: one slot per issued read, released on
// pop; misuse in either direction latches the sticky credit_err.
module grayscale_sidebuf_credit #(
   parameter int DEPTH = 64,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rd_issue,
   input  logic             pop,
   output logic [CNT_W-1:0] reserved,
   output logic             credit_ok,
   output logic             credit_err
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [CNT_W-1:0] reserved_q;
   logic [CNT_W-1:0] reserved_next;
   logic             credit_err_q;
   logic             inc;
   logic             dec;
   logic             bad_issue;
   logic             bad_pop;

   assign credit_ok = (reserved_q < FULL);
   assign inc       = rd_issue && credit_ok;
   assign bad_issue = rd_issue && !credit_ok;
   assign dec       = pop && (reserved_q != '0);
   assign bad_pop   = pop && (reserved_q == '0);

   // An illegal pop at zero is ignored rather than wrapping the counter.
   always_comb begin
      reserved_next = reserved_q;
      case ({inc, dec})
         2'b10:   reserved_next = reserved_q + CNT_W'(1);
         2'b01:   reserved_next = reserved_q - CNT_W'(1);
         default: reserved_next = reserved_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reserved_q   <= '0;
         credit_err_q <= 1'b0;
      end else begin
         reserved_q   <= reserved_next;
         credit_err_q <= credit_err_q | bad_issue | bad_pop;
      end
   end

   assign reserved   = reserved_q;
   assign credit_err = credit_err_q;

endmodule

// File: rtl/grayscale_sidebuf.sv
// Side buffer absorbing grayscale result lines (no backpressure) and
// draining them to the write-request path under valid/ready.
module grayscale_sidebuf
   import grayscale_pkg::*;
#(
   parameter int DEPTH      = SIDEBUF_DEPTH,
   parameter int DATA_WIDTH = 512,
   parameter int CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   grayscale_sidebuf_if.slave   bus,
   output logic [CNT_W-1:0]     count,
   output logic [CNT_W-1:0]     reserved,
   output logic [CNT_W-1:0]     high_water,
   output logic                 overflow,
   output logic                 credit_err
);

   localparam int               AW   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wp;
   logic [AW-1:0]         rp;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_next;
   logic [CNT_W-1:0]      high_water_q;
   logic                  overflow_q;
   logic                  push;
   logic                  pop;
   logic                  drop;

   assign bus.valid_out = (count_q != '0);
   assign bus.data_out  = mem[rp];

   // A full buffer still accepts a beat when the head leaves in the same cycle.
   assign pop  = bus.valid_out && bus.ready_in;
   assign push = bus.valid_in && ((count_q < FULL) || pop);
   assign drop = bus.valid_in && !push;

   always_comb begin
      count_next = count_q;
      case ({push, pop})
         2'b10:   count_next = count_q + CNT_W'(1);
         2'b01:   count_next = count_q - CNT_W'(1);
         default: count_next = count_q;
      endcase
   end

   // Line storage carries no reset; valid_out masks stale contents.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem[wp] <= bus.data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp           <= '0;
         rp           <= '0;
         count_q      <= '0;
         high_water_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop)  rp <= rp + AW'(1);
         count_q      <= count_next;
         high_water_q <= (count_next > high_water_q) ? count_next : high_water_q;
         overflow_q   <= overflow_q | drop;
      end
   end

   grayscale_sidebuf_credit #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_credit (
      .clk        (clk),
      .reset      (reset),
      .rd_issue   (bus.rd_issue),
      .pop        (pop),
      .reserved   (reserved),
      .credit_ok  (bus.credit_ok),
      .credit_err (credit_err)
   );

   assign count      = count_q;
   assign high_water = high_water_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_grayscale_sidebuf.sv
// Directed testbench for grayscale_sidebuf: ordering, credits, overflow,
// full-buffer pass-through across pointer wrap and mid-stream reset.
module tb_grayscale_sidebuf;
   import grayscale_pkg::*;

   localparam int DEPTH = 64;
   localparam int DW    = 512;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          reset;
   logic [CW-1:0] count;
   logic [CW-1:0] reserved;
   logic [CW-1:0] high_water;
   logic          overflow;
   logic          credit_err;

   int checks = 0;
   int errors = 0;

   grayscale_sidebuf_if #(.DATA_WIDTH(DW)) bus ();

   grayscale_sidebuf #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DW),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .count      (count),
      .reserved   (reserved),
      .high_water (high_water),
      .overflow   (overflow),
      .credit_err (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic t_sidebuf_line line_of(input int i);
      return {16{32'hA5A50000 ^ 32'(i)}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      bus.rd_issue = 1'b0;
      bus.ready_in = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (count !== 0 || reserved !== 0 || high_water !== 0) begin
         errors++;
         $display("[TB] FAIL reset_counters count=%0d reserved=%0d hw=%0d required 0/0/0", count, reserved, high_water);
      end
      checks++;
      if (bus.valid_out !== 1'b0 || bus.credit_ok !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_handshake valid_out=%b credit_ok=%b required 0/1", bus.valid_out, bus.credit_ok);
      end
      checks++;
      if (overflow !== 1'b0 || credit_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags overflow=%b credit_err=%b required 0/0", overflow, credit_err);
      end
   endtask

   task automatic test_push_pop();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         bus.valid_in = 1'b1;
         bus.data_in  = line_of(i);
         bus.rd_issue = 1'b1;
         tick();
      end
      idle_inputs();
      checks++;
      if (count !== 10 || high_water !== 10 || reserved !== 10) begin
         errors++;
         $display("[TB] FAIL fill10 count=%0d hw=%0d reserved=%0d required 10/10/10", count, high_water, reserved);
      end
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== line_of(0)) begin
         errors++;
         $display("[TB] FAIL fill10_head valid_out=%b data=%h required 1/%h", bus.valid_out, bus.data_out[31:0], line_of(0) & 512'hFFFFFFFF);
      end
      bus.ready_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (bus.valid_out !== 1'b1 || bus.data_out !== line_of(i)) begin
            errors++;
            $display("[TB] FAIL drain_order idx=%0d valid_out=%b data=%h required 1/%h", i, bus.valid_out, bus.data_out[31:0], 32'hA5A50000 ^ 32'(i));
         end
         tick();
      end
      bus.ready_in = 1'b0;
      checks++;
      if (count !== 0 || bus.valid_out !== 1'b0 || reserved !== 0 || high_water !== 10 || credit_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drain_done count=%0d valid_out=%b reserved=%0d hw=%0d cerr=%b required 0/0/0/10/0", count, bus.valid_out, reserved, high_water, credit_err);
      end
   endtask

   task automatic test_credit();
      do_reset();
      bus.rd_issue = 1'b1;
      for (int i = 0; i < 63; i++) tick();
      checks++;
      if (bus.credit_ok !== 1'b1 || reserved !== 63) begin
         errors++;
         $display("[TB] FAIL credit_63 credit_ok=%b reserved=%0d required 1/63", bus.credit_ok, reserved);
      end
      tick();
      checks++;
      if (bus.credit_ok !== 1'b0 || reserved !== 64 || credit_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL credit_64 credit_ok=%b reserved=%0d cerr=%b required 0/64/0", bus.credit_ok, reserved, credit_err);
      end
      tick();
      bus.rd_issue = 1'b0;
      checks++;
      if (credit_err !== 1'b1 || reserved !== 64) begin
         errors++;
         $display("[TB] FAIL credit_65 cerr=%b reserved=%0d required 1/64", credit_err, reserved);
      end
      tick();
      checks++;
      if (credit_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL credit_sticky cerr=%b required 1", credit_err);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         bus.valid_in = 1'b1;
         bus.data_in  = line_of(i);
         bus.rd_issue = 1'b1;
         tick();
      end
      bus.rd_issue = 1'b0;
      checks++;
      if (count !== 64 || overflow !== 1'b0 || bus.credit_ok !== 1'b0) begin
         errors++;
         $display("[TB] FAIL full64 count=%0d overflow=%b credit_ok=%b required 64/0/0", count, overflow, bus.credit_ok);
      end
      bus.data_in = line_of(100);
      tick();
      idle_inputs();
      checks++;
      if (overflow !== 1'b1 || count !== 64 || bus.data_out !== line_of(0)) begin
         errors++;
         $display("[TB] FAIL overflow overflow=%b count=%0d head=%h required 1/64/%h", overflow, count, bus.data_out[31:0], 32'hA5A50000);
      end
      tick();
      checks++;
      if (overflow !== 1'b1 || credit_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL overflow_sticky overflow=%b cerr=%b required 1/0", overflow, credit_err);
      end
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         bus.valid_in = 1'b1;
         bus.data_in  = line_of(i);
         bus.rd_issue = 1'b1;
         tick();
      end
      bus.rd_issue = 1'b0;
      bus.ready_in = 1'b1;
      for (int k = 0; k < 70; k++) begin
         bus.data_in = line_of(DEPTH + k);
         checks++;
         if (bus.data_out !== line_of(k)) begin
            errors++;
            $display("[TB] FAIL wrap_order idx=%0d data=%h required %h", k, bus.data_out[31:0], 32'hA5A50000 ^ 32'(k));
         end
         tick();
      end
      idle_inputs();
      checks++;
      if (count !== 64 || overflow !== 1'b0 || high_water !== 64) begin
         errors++;
         $display("[TB] FAIL wrap_full count=%0d overflow=%b hw=%0d required 64/0/64", count, overflow, high_water);
      end
      checks++;
      if (bus.data_out !== line_of(70)) begin
         errors++;
         $display("[TB] FAIL wrap_head data=%h required %h", bus.data_out[31:0], 32'hA5A50000 ^ 32'd70);
      end
   endtask

   task automatic test_empty_passthrough();
      do_reset();
      bus.valid_in = 1'b1;
      bus.data_in  = line_of(200);
      bus.rd_issue = 1'b1;
      bus.ready_in = 1'b1;
      checks++;
      if (bus.valid_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL empty_no_valid valid_out=%b required 0", bus.valid_out);
      end
      tick();
      bus.valid_in = 1'b0;
      bus.rd_issue = 1'b0;
      checks++;
      if (count !== 1 || bus.valid_out !== 1'b1 || bus.data_out !== line_of(200)) begin
         errors++;
         $display("[TB] FAIL empty_next count=%0d valid_out=%b data=%h required 1/1/%h", count, bus.valid_out, bus.data_out[31:0], 32'hA5A50000 ^ 32'd200);
      end
      tick();
      bus.ready_in = 1'b0;
      checks++;
      if (count !== 0 || bus.valid_out !== 1'b0 || reserved !== 0 || credit_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL empty_popped count=%0d valid_out=%b reserved=%0d cerr=%b required 0/0/0/0", count, bus.valid_out, reserved, credit_err);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 30; i++) begin
         bus.valid_in = (i < 17);
         bus.data_in  = line_of(300 + i);
         bus.rd_issue = 1'b1;
         tick();
      end
      idle_inputs();
      checks++;
      if (count !== 17 || reserved !== 30) begin
         errors++;
         $display("[TB] FAIL pre_reset count=%0d reserved=%0d required 17/30", count, reserved);
      end
      reset        = 1'b1;
      bus.valid_in = 1'b1;
      bus.rd_issue = 1'b1;
      tick();
      reset = 1'b0;
      idle_inputs();
      checks++;
      if (count !== 0 || reserved !== 0 || high_water !== 0 || bus.valid_out !== 1'b0 || bus.credit_ok !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_reset count=%0d reserved=%0d hw=%0d valid_out=%b credit_ok=%b required 0/0/0/0/1", count, reserved, high_water, bus.valid_out, bus.credit_ok);
      end
      checks++;
      if (overflow !== 1'b0 || credit_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset_flags overflow=%b cerr=%b required 0/0", overflow, credit_err);
      end
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      #2;
      test_reset();
      test_push_pop();
      test_credit();
      test_overflow();
      test_full_wrap();
      test_empty_passthrough();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
